// File: rtl/bus_cycle_generator.sv
`default_nettype none
// ============================================================================
//  Module      : bus_cycle_generator
//  Description : 8086-style bus cycle sequencer (T1/T2/T3/TW/T4 plus HALT).
//                It drives the S2..S0 status code toward an 8288, holds the
//                address and write data, and captures read data.
//                Optional macro BUS_CYCLE_INTA_PAIR_EN: when it is defined,
//                an INTA request runs two back-to-back INTA cycles separated
//                by one passive clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_cycle_generator (
    input  logic        clock,
    input  logic        reset,
    input  logic        request,
    input  logic [2:0]  request_type,
    input  logic [19:0] request_address,
    input  logic [7:0]  request_write_data,
    input  logic        ready,
    input  logic        wake,
    input  logic [7:0]  data_in,
    output logic [2:0]  processor_status,
    output logic [19:0] address,
    output logic [7:0]  data_out,
    output logic        data_out_enable,
    output logic [7:0]  read_data,
    output logic        acknowledge,
    output logic        busy,
    output logic [3:0]  wait_states
);

    typedef enum logic [2:0] {
        c_idle   = 3'd0,
        c_t1     = 3'd1,
        c_t2     = 3'd2,
        c_t3     = 3'd3,
        c_tw     = 3'd4,
        c_t4     = 3'd5,
        c_halted = 3'd6
    } state_t;

    localparam logic [2:0] c_code_inta      = 3'b000;
    localparam logic [2:0] c_code_io_read   = 3'b001;
    localparam logic [2:0] c_code_io_write  = 3'b010;
    localparam logic [2:0] c_code_halt      = 3'b011;
    localparam logic [2:0] c_code_fetch     = 3'b100;
    localparam logic [2:0] c_code_mem_read  = 3'b101;
    localparam logic [2:0] c_code_mem_write = 3'b110;
    localparam logic [2:0] c_code_none      = 3'b111;
    localparam logic [3:0] c_wait_max       = 4'd15;

`ifdef BUS_CYCLE_INTA_PAIR_EN
    localparam bit c_inta_pair = 1'b1;
`else
    localparam bit c_inta_pair = 1'b0;
`endif

    state_t      r_state;
    state_t      w_next_state;
    logic        w_accept;
    logic [2:0]  r_type;
    logic [19:0] r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_read_data;
    logic [3:0]  r_wait;
    logic        r_pair_first;   // first half of an INTA pair is in flight
    logic        r_pair_gap;     // passive clock between the two INTA halves
    logic        w_is_write;
    logic        w_is_read;
    logic        w_capture;
    logic        w_active;

    // Decode the latched cycle class.
    always_comb begin
        w_is_write = (r_type == c_code_io_write) || (r_type == c_code_mem_write);
        w_is_read  = (r_type == c_code_inta)  || (r_type == c_code_io_read) ||
                     (r_type == c_code_fetch) || (r_type == c_code_mem_read);
        w_capture  = ((r_state == c_t3) || (r_state == c_tw)) && ready && w_is_read;
        w_active   = (r_state == c_t1) || (r_state == c_t2) ||
                     (r_state == c_t3) || (r_state == c_tw);
    end

    // Next-state logic and request acceptance.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            c_idle: begin
                if (r_pair_gap) begin
                    w_next_state = c_t1;
                end else if (request) begin
                    w_accept     = 1'b1;
                    w_next_state = (request_type == c_code_none) ? c_t4 : c_t1;
                end
            end
            c_t1:     w_next_state = (r_type == c_code_halt) ? c_halted : c_t2;
            c_t2:     w_next_state = c_t3;
            c_t3,
            c_tw:     w_next_state = ready ? c_t4 : c_tw;
            c_t4: begin
                if (r_pair_first) begin
                    w_next_state = c_idle;
                end else if (request) begin
                    w_accept     = 1'b1;
                    w_next_state = (request_type == c_code_none) ? c_t4 : c_t1;
                end else begin
                    w_next_state = c_idle;
                end
            end
            c_halted: begin
                if (wake) begin
                    w_next_state = c_t4;
                end
            end
            default:  w_next_state = c_idle;
        endcase
    end

    // State, latched request fields, read capture and wait counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_idle;
            r_type       <= c_code_none;
            r_addr       <= 20'd0;
            r_wdata      <= 8'd0;
            r_read_data  <= 8'd0;
            r_wait       <= 4'd0;
            r_pair_first <= 1'b0;
            r_pair_gap   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_type  <= request_type;
                r_addr  <= request_address;
                r_wdata <= request_write_data;
            end
            if (w_capture) begin
                r_read_data <= data_in;
            end
            if (w_next_state == c_t1) begin
                r_wait <= 4'd0;
            end else if ((w_next_state == c_tw) && (r_wait != c_wait_max)) begin
                r_wait <= r_wait + 4'd1;
            end
            if (w_accept) begin
                r_pair_first <= c_inta_pair && (request_type == c_code_inta);
            end else if ((r_state == c_t4) && r_pair_first) begin
                r_pair_first <= 1'b0;
                r_pair_gap   <= 1'b1;
            end
            if ((r_state == c_idle) && r_pair_gap) begin
                r_pair_gap <= 1'b0;
            end
        end
    end

    // Output decode; status is passive outside T1..TW so cycles never abut.
    always_comb begin
        processor_status = w_active ? r_type : c_code_none;
        address          = r_addr;
        data_out         = r_wdata;
        data_out_enable  = w_is_write && ((r_state == c_t2) || (r_state == c_t3) ||
                                          (r_state == c_tw) || (r_state == c_t4));
        read_data        = r_read_data;
        acknowledge      = (r_state == c_t4) && !r_pair_first;
        busy             = (r_state != c_idle);
        wait_states      = r_wait;
    end

endmodule
`default_nettype wire
